// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store controller between the CPU memory stage and a
// word-only data memory. Byte, halfword and word accesses are mapped onto
// aligned 32-bit memory cycles. Sub-word stores use a read-modify-write.
// Sub-word loads are sign- or zero-extended.
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   Defined:   misaligned halfword/word accesses go to an ERR state and end
//              with err+done and no memory access.
//   Undefined: misaligned low address bits are ignored and err is tied 0.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   req, we, size,     CPU request. size: 00 byte, 01 half, 1x word.
//   sign_ext, addr,
//   wdata
//   rdata              extended load result, held until the next load ends
//   busy, done, err    handshake status back to the CPU
//   m_read, m_write    data memory strobes (never high together)
//   m_addr, m_din      word address and write data to memory
//   m_dout             combinational read data from memory
module lsu_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        m_read,
  output logic        m_write,
  output logic [31:0] m_addr,
  output logic [31:0] m_din,
  input  logic [31:0] m_dout
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STORE_W,
    RMW_RD,
    RMW_WR
`ifdef LSU_MISALIGN_TRAP_EN
    , ERR
`endif
  } state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        sign_ext_q;
  logic        we_q;
  logic [31:0] merge_q;

  logic [31:0] load_val;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] merged;

  // Lane extraction and extension of the memory word for loads. Only the
  // latched request fields steer the selection.
  always_comb begin
    byte_sel = m_dout[{addr_q[1:0], 3'b000} +: 8];
    half_sel = addr_q[1] ? m_dout[31:16] : m_dout[15:0];
    load_val = m_dout;
    case (size_q)
      2'b00:   load_val = {{24{sign_ext_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_val = {{16{sign_ext_q & half_sel[15]}}, half_sel};
      default: load_val = m_dout;
    endcase
  end

  // Merge the store lane into the word captured during RMW_RD. The other
  // bytes keep the values read from memory.
  always_comb begin
    merged = merge_q;
    if (size_q == 2'b00)
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  // Memory-side decode depends only on state and latched fields, so the
  // CPU inputs have no combinational path to the memory port.
  assign busy    = (state != IDLE);
  assign m_read  = (state == LOAD) || (state == RMW_RD);
  assign m_write = ((state == STORE_W) || (state == RMW_WR)) && we_q;
  assign m_addr  = {addr_q[31:2], 2'b00};
  assign m_din   = (state == RMW_WR) ? merged : wdata_q;

`ifndef LSU_MISALIGN_TRAP_EN
  assign err = 1'b0;
`endif

`ifdef LSU_MISALIGN_TRAP_EN
  // A halfword with addr[0] set, or a word with any low bit set, traps.
  logic misaligned;
  assign misaligned = ((size == 2'b01) && addr[0]) ||
                      (size[1] && (addr[1:0] != 2'b00));
`endif

  // Main controller. done/err are one-cycle pulses and default low. The
  // request fields are captured only when a request is accepted in IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      sign_ext_q <= 1'b0;
      we_q       <= 1'b0;
      merge_q    <= '0;
      rdata      <= '0;
      done       <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      err        <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      err  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (req) begin
            addr_q     <= addr;
            wdata_q    <= wdata;
            size_q     <= size;
            sign_ext_q <= sign_ext;
            we_q       <= we;
`ifdef LSU_MISALIGN_TRAP_EN
            if (misaligned)
              state <= ERR;
            else
`endif
            if (!we)
              state <= LOAD;
            else if (size[1])
              state <= STORE_W;
            else
              state <= RMW_RD;
          end
        end
        LOAD: begin
          rdata <= load_val;
          done  <= 1'b1;
          state <= IDLE;
        end
        STORE_W: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        RMW_RD: begin
          merge_q <= m_dout;
          state   <= RMW_WR;
        end
        RMW_WR: begin
          done  <= 1'b1;
          state <= IDLE;
        end
`ifdef LSU_MISALIGN_TRAP_EN
        ERR: begin
          done  <= 1'b1;
          err   <= 1'b1;
          state <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed bench for lsu_ctrl with a word memory model and a
// scoreboard of expected completions.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;
  logic        done;
  logic        err;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_addr;
  logic [31:0] m_din;
  logic [31:0] m_dout;

  logic [31:0] mem [0:63];

  int          vectors     = 0;
  int          miscompares = 0;
  int          read_cnt    = 0;
  int          write_cnt   = 0;
  int          overlap_cnt = 0;
  logic [31:0] last_din    = '0;

  typedef struct {
    string       tag;
    int          exp_lat;
    bit          chk_rd;
    logic [31:0] exp_rd;
    int          exp_reads;
    int          exp_writes;
    bit          chk_din;
    logic [31:0] exp_din;
    logic        exp_err;
    int          rd_base;
    int          wr_base;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  lsu_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .we       (we),
    .size     (size),
    .sign_ext (sign_ext),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .m_read   (m_read),
    .m_write  (m_write),
    .m_addr   (m_addr),
    .m_din    (m_din),
    .m_dout   (m_dout)
  );

  // Combinational word memory, written mid-cycle while m_write is high.
  assign m_dout = mem[m_addr[7:2]];

  always @(negedge clk) begin
    if (m_read) read_cnt++;
    if (m_read && m_write) overlap_cnt++;
    if (m_write) begin
      write_cnt++;
      last_din = m_din;
      mem[m_addr[7:2]] = m_din;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive a request and push what its completion must look like.
  task automatic applyStimulus(input string tag, input logic w,
                               input logic [1:0] sz, input logic se,
                               input logic [31:0] a, input logic [31:0] wd,
                               input int lat, input bit chk_rd,
                               input logic [31:0] exp_rd, input int nrd,
                               input int nwr, input bit chk_din,
                               input logic [31:0] exp_din, input logic exp_err);
    exp_t e;
    we = w; size = sz; sign_ext = se; addr = a; wdata = wd; req = 1'b1;
    e.tag = tag; e.exp_lat = lat; e.chk_rd = chk_rd; e.exp_rd = exp_rd;
    e.exp_reads = nrd; e.exp_writes = nwr; e.chk_din = chk_din;
    e.exp_din = exp_din; e.exp_err = exp_err;
    e.rd_base = read_cnt; e.wr_base = write_cnt;
    sb.push_back(e);
  endtask

  task automatic retireAccess(input int edges);
    exp_t e;
    e = sb.pop_front();
    checkOutput({e.tag, "/latency"}, 32'(edges), 32'(e.exp_lat));
    checkOutput({e.tag, "/err"}, {31'b0, err}, {31'b0, e.exp_err});
    checkOutput({e.tag, "/reads"}, 32'(read_cnt - e.rd_base), 32'(e.exp_reads));
    checkOutput({e.tag, "/writes"}, 32'(write_cnt - e.wr_base), 32'(e.exp_writes));
    if (e.chk_rd) checkOutput({e.tag, "/rdata"}, rdata, e.exp_rd);
    if (e.chk_din) checkOutput({e.tag, "/m_din"}, last_din, e.exp_din);
  endtask

  // Edge counts are relative to the edge that accepted the request.
  task automatic drain(input int max_edges);
    int edges = 0;
    while (sb.size() > 0 && edges < max_edges) begin
      @(posedge clk); #1;
      edges++;
      if (done) retireAccess(edges);
    end
    if (sb.size() > 0) begin
      checkOutput("timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic doAccess(input string tag, input logic w, input logic [1:0] sz,
                          input logic se, input logic [31:0] a,
                          input logic [31:0] wd, input int lat, input bit chk_rd,
                          input logic [31:0] exp_rd, input int nrd, input int nwr,
                          input bit chk_din, input logic [31:0] exp_din,
                          input logic exp_err);
    @(negedge clk);
    applyStimulus(tag, w, sz, se, a, wd, lat, chk_rd, exp_rd, nrd, nwr,
                  chk_din, exp_din, exp_err);
    @(posedge clk); #1;
    req = 1'b0;
    drain(12);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int edges;
    int ndone;
    int wbase;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0;
    addr = '0; wdata = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset/busy", {31'b0, busy}, 32'd0);
    checkOutput("reset/done", {31'b0, done}, 32'd0);
    checkOutput("reset/err", {31'b0, err}, 32'd0);
    checkOutput("reset/m_read", {31'b0, m_read}, 32'd0);
    checkOutput("reset/m_write", {31'b0, m_write}, 32'd0);
    checkOutput("reset/rdata", rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Word store then word load
    doAccess("sw_10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1, 1'b0, '0,
             0, 1, 1'b1, 32'hDEADBEEF, 1'b0);
    doAccess("lw_10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1, 1'b1, 32'hDEADBEEF,
             1, 0, 1'b0, '0, 1'b0);

    // size=11 behaves as a word
    mem[4] = 32'h11223344;
    doAccess("l11_10", 1'b0, 2'b11, 1'b1, 32'h10, 32'h0, 1, 1'b1, 32'h11223344,
             1, 0, 1'b0, '0, 1'b0);

    // Byte store read-modify-write; upper wdata bits must be ignored
    doAccess("sb_12", 1'b1, 2'b00, 1'b0, 32'h12, 32'hFFFFFFA5, 2, 1'b0, '0,
             1, 1, 1'b1, 32'h11A53344, 1'b0);

    // Byte loads with both extensions
    mem[4] = 32'h80FF0000;
    doAccess("lb_13", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1, 1'b1, 32'hFFFFFF80,
             1, 0, 1'b0, '0, 1'b0);
    doAccess("lbu_13", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1, 1'b1, 32'h00000080,
             1, 0, 1'b0, '0, 1'b0);

    // Halfword loads on both lanes
    mem[5] = 32'h80011234;
    doAccess("lh_16", 1'b0, 2'b01, 1'b1, 32'h16, 32'h0, 1, 1'b1, 32'hFFFF8001,
             1, 0, 1'b0, '0, 1'b0);
    doAccess("lh_14", 1'b0, 2'b01, 1'b1, 32'h14, 32'h0, 1, 1'b1, 32'h00001234,
             1, 0, 1'b0, '0, 1'b0);
    doAccess("lhu_16", 1'b0, 2'b01, 1'b0, 32'h16, 32'h0, 1, 1'b1, 32'h00008001,
             1, 0, 1'b0, '0, 1'b0);

    // Halfword store to lane 0, then read a byte back through memory
    doAccess("sh_14", 1'b1, 2'b01, 1'b0, 32'h14, 32'h1234BEEF, 2, 1'b0, '0,
             1, 1, 1'b1, 32'h8001BEEF, 1'b0);
    doAccess("lb_15", 1'b0, 2'b00, 1'b1, 32'h15, 32'h0, 1, 1'b1, 32'hFFFFFFBE,
             1, 0, 1'b0, '0, 1'b0);

    // Request changed and held during RMW is ignored until done
    mem[6] = 32'h0;
    @(negedge clk);
    applyStimulus("sb_busy", 1'b1, 2'b00, 1'b0, 32'h19, 32'h00000077, 2, 1'b0,
                  '0, 1, 1, 1'b1, 32'h00007700, 1'b0);
    @(posedge clk); #1;
    applyStimulus("lw_after", 1'b0, 2'b10, 1'b0, 32'h18, 32'h0, 4, 1'b1,
                  32'h00007700, 2, 1, 1'b1, 32'h00007700, 1'b0);
    edges = 0;
    ndone = 0;
    while (sb.size() > 0 && edges < 12) begin
      @(posedge clk); #1;
      edges++;
      if (edges == 3) req = 1'b0;
      if (done) begin
        ndone++;
        retireAccess(edges);
      end
    end
    if (sb.size() > 0) begin
      checkOutput("busy_req/timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("busy_req/done_count", 32'(ndone), 32'd2);
    checkOutput("busy_req/idle_busy", {31'b0, busy}, 32'd0);

    // Misaligned accesses
    mem[8] = 32'hCAFE5678;
`ifdef LSU_MISALIGN_TRAP_EN
    doAccess("lh_21", 1'b0, 2'b01, 1'b0, 32'h21, 32'h0, 1, 1'b1, 32'h00007700,
             0, 0, 1'b0, '0, 1'b1);
    doAccess("lw_22", 1'b0, 2'b10, 1'b0, 32'h22, 32'h0, 1, 1'b1, 32'h00007700,
             0, 0, 1'b0, '0, 1'b1);
`else
    doAccess("lh_21", 1'b0, 2'b01, 1'b0, 32'h21, 32'h0, 1, 1'b1, 32'h00005678,
             1, 0, 1'b0, '0, 1'b0);
    doAccess("lw_22", 1'b0, 2'b10, 1'b0, 32'h22, 32'h0, 1, 1'b1, 32'hCAFE5678,
             1, 0, 1'b0, '0, 1'b0);
`endif

    // Reset during RMW_RD abandons the store
    mem[7] = 32'h12345678;
    @(negedge clk);
    we = 1'b1; size = 2'b00; sign_ext = 1'b0; addr = 32'h1C;
    wdata = 32'h00000099; req = 1'b1;
    wbase = write_cnt;
    @(posedge clk); #1;
    req = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_rmw/busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_rmw/m_read", {31'b0, m_read}, 32'd0);
    checkOutput("rst_rmw/m_write", {31'b0, m_write}, 32'd0);
    checkOutput("rst_rmw/done", {31'b0, done}, 32'd0);
    checkOutput("rst_rmw/rdata", rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_rmw/writes", 32'(write_cnt - wbase), 32'd0);
    checkOutput("rst_rmw/mem", mem[7], 32'h12345678);
    checkOutput("overlap", 32'(overlap_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
